// File: rtl/hexin_entry_pkg.sv
// Shared definitions for the operator-entry front end of the 8-bit core.
// Provides the FSM state encoding, default timing parameters and the
// counter width rule used by hexin_entry_ctrl.
package hexin_entry_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_STROBE_CYCLES   = 30;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DB_PRESS = 3'd1;
    localparam logic [2:0] ST_STROBE   = 3'd2;
    localparam logic [2:0] ST_WAIT_REL = 3'd3;
    localparam logic [2:0] ST_DB_REL   = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        DB_PRESS = ST_DB_PRESS,
        STROBE   = ST_STROBE,
        WAIT_REL = ST_WAIT_REL,
        DB_REL   = ST_DB_REL
    } state_t;

    // One counter serves both debounce and strobe timing; it must reach max-1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hexin_entry_ctrl_btn_sync.sv
// Two-flop synchroniser for the asynchronous enter button.
// Ports: clk (clock), rst (async active-high clear), d (raw input),
//        q (synchronised output).
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hexin_entry_ctrl.sv
// Operator-input stage: debounces the enter button, latches the switch word
// into HEXIN and issues one fixed-width CNTRPIN strobe per physical press.
// Ports:
//   Clk, Clr      clock / async active-high reset
//   SWIN [DW]     raw switch word, sampled only on the capture edge
//   BTN           raw enter button (asynchronous, bouncy)
//   HLT           core halted; blocks new presses and cuts a running strobe
//   HEXIN [DW]    latched input word
//   CNTRPIN       input-ready strobe, STROBE_CYCLES wide
//   BUSY          FSM not idle
//   PRESS_CNT [8] strobes issued, wraps at 256
module hexin_entry_ctrl
    import hexin_entry_pkg::*;
#(
    parameter int unsigned DW              = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned STROBE_CYCLES   = DEF_STROBE_CYCLES
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic [DW-1:0] SWIN,
    input  logic          BTN,
    input  logic          HLT,
    output logic [DW-1:0] HEXIN,
    output logic          CNTRPIN,
    output logic          BUSY,
    output logic [7:0]    PRESS_CNT
);

    localparam int unsigned CW       = cnt_width(DEBOUNCE_CYCLES, STROBE_CYCLES);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STROBE_CYCLES - 1);

    logic          btn_s;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] hexin_nxt;
    logic          cntrpin_nxt;
    logic [7:0]    press_cnt_nxt;

    btn_sync u_btn_sync (
        .clk (Clk),
        .rst (Clr),
        .d   (BTN),
        .q   (btn_s)
    );

    // State and output registers; BUSY is registered from the next state.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state     <= IDLE;
            cnt       <= '0;
            HEXIN     <= '0;
            CNTRPIN   <= 1'b0;
            BUSY      <= 1'b0;
            PRESS_CNT <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            HEXIN     <= hexin_nxt;
            CNTRPIN   <= cntrpin_nxt;
            BUSY      <= (state_nxt != IDLE);
            PRESS_CNT <= press_cnt_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hexin_nxt     = HEXIN;
        cntrpin_nxt   = CNTRPIN;
        press_cnt_nxt = PRESS_CNT;

        unique case (state)
            IDLE: begin
                if (btn_s && !HLT) begin
                    state_nxt = DB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                end else if (cnt == DB_LAST) begin
                    // Capture edge: latch switches and start the strobe together.
                    state_nxt     = STROBE;
                    cnt_nxt       = '0;
                    hexin_nxt     = SWIN;
                    cntrpin_nxt   = 1'b1;
                    press_cnt_nxt = PRESS_CNT + 8'd1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STROBE: begin
                if (HLT || (cnt == STB_LAST)) begin
                    state_nxt   = WAIT_REL;
                    cntrpin_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_REL: begin
                if (!btn_s) begin
                    state_nxt = DB_REL;
                    cnt_nxt   = '0;
                end
            end
            DB_REL: begin
                if (btn_s) begin
                    state_nxt = WAIT_REL;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                cntrpin_nxt = 1'b0;
            end
        endcase
    end

endmodule
